// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one integer ALU between two requesters with busy tracking.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0 first).
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            I_clk,
  input  logic            I_reset,
  input  logic            I_req0,
  input  logic            I_req1,
  input  logic [OPW-1:0]  I_op0,
  input  logic [OPW-1:0]  I_op1,
  input  logic [XLEN-1:0] I_a0,
  input  logic [XLEN-1:0] I_a1,
  input  logic [XLEN-1:0] I_b0,
  input  logic [XLEN-1:0] I_b1,
  output logic            O_gnt0,
  output logic            O_gnt1,
  output logic            O_done0,
  output logic            O_done1,
  output logic [XLEN-1:0] O_rdata,
  output logic            O_lt,
  output logic            O_ltu,
  output logic            O_eq,
  output logic            O_busy,
  output logic            O_alu_en,
  output logic [OPW-1:0]  O_alu_op,
  output logic [XLEN-1:0] O_alu_s1,
  output logic [XLEN-1:0] O_alu_s2,
  input  logic            I_alu_busy,
  input  logic [XLEN-1:0] I_alu_data,
  input  logic            I_alu_lt,
  input  logic            I_alu_ltu,
  input  logic            I_alu_eq
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              lt_q, lt_d, ltu_q, ltu_d, eq_q, eq_d;
  logic [1:0]        done_q, done_d;
  logic              grant;
  logic              win;

  assign grant = (state_q == S_IDLE) && (I_req0 || I_req1) && !I_reset;

`ifdef ALU_ARB_RR_EN
  logic ptr_q;

  // On a conflict the port that was not granted last wins.
  always_comb begin
    win = ~I_req0;
    if (I_req0 && I_req1) win = ~ptr_q;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset)    ptr_q <= 1'b1;
    else if (grant) ptr_q <= win;
  end
`else
  always_comb win = ~I_req0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rdata_d = rdata_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    eq_d    = eq_q;
    done_d  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          owner_d = win;
          op_d    = win ? I_op1 : I_op0;
          a_d     = win ? I_a1  : I_a0;
          b_d     = win ? I_b1  : I_b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_WAIT;
      S_WAIT: begin
        if (!I_alu_busy) begin
          rdata_d = I_alu_data;
          lt_d    = I_alu_lt;
          ltu_d   = I_alu_ltu;
          eq_d    = I_alu_eq;
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rdata_q <= '0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
      eq_q    <= 1'b0;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rdata_q <= rdata_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
      eq_q    <= eq_d;
      done_q  <= done_d;
    end
  end

  // Enable follows ALU busy in WAIT so a finished shift is never restarted.
  assign O_alu_en = (state_q == S_EXEC) || ((state_q == S_WAIT) && I_alu_busy);
  assign O_gnt0   = grant && !win;
  assign O_gnt1   = grant && win;
  assign O_done0  = done_q[0];
  assign O_done1  = done_q[1];
  assign O_busy   = (state_q != S_IDLE);
  assign O_alu_op = op_q;
  assign O_alu_s1 = a_q;
  assign O_alu_s2 = b_q;
  assign O_rdata  = rdata_q;
  assign O_lt     = lt_q;
  assign O_ltu    = ltu_q;
  assign O_eq     = eq_q;

endmodule
